// File: rtl/axil_init_sequencer.sv
// Table-driven AXI4-Lite bring-up master: replays a compile-time register write table after
// reset or on start, with optional read-back compare, per-channel timeout and bounded retry.
module axil_init_sequencer #(
  parameter int                             NUM_ENTRIES    = 2,
  parameter int                             ADDR_W         = 32,
  parameter logic [NUM_ENTRIES*ADDR_W-1:0]  INIT_ADDR      = {32'h0000_0408, 32'h0000_0404},
  parameter logic [NUM_ENTRIES*32-1:0]      INIT_DATA      = {32'h1000_0000, 32'h1000_0000},
  parameter logic [NUM_ENTRIES-1:0]         VERIFY_MASK    = '0,
  parameter int                             STARTUP_DELAY  = 100,
  parameter int                             TIMEOUT_CYCLES = 1024,
  parameter int                             MAX_RETRIES    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [5:0]        err_index,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);
  localparam int          CNT_MAX  = (STARTUP_DELAY > TIMEOUT_CYCLES) ? STARTUP_DELAY : TIMEOUT_CYCLES;
  localparam int          CNT_W    = $clog2(CNT_MAX + 1) + 1;
  localparam int          RTY_W    = $clog2(MAX_RETRIES + 2);
  localparam int          DLY_LAST = (STARTUP_DELAY > 0) ? STARTUP_DELAY - 1 : 0;
  localparam logic [63:0] VMASK    = 64'(VERIFY_MASK);
  localparam logic [5:0]  LAST_IDX = 6'(NUM_ENTRIES - 1);
  localparam bit          HAS_VFY  = (VERIFY_MASK != '0);

  typedef enum logic [2:0] {DELAY, WRITE, BRESP, RADDR, RDATA, NEXT, DONE, ERROR} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [5:0]         idx_q, idx_d, tbl_idx;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic               awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic               arvalid_q, arvalid_d, rready_q, rready_d;
  logic               aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [ADDR_W-1:0]  awaddr_q, awaddr_d, araddr_q, araddr_d, tbl_addr;
  logic [31:0]        wdata_q, wdata_d, tbl_data;
  logic [5:0]         err_index_q, err_index_d;
  logic [1:0]         err_code_q, err_code_d, fail_code;
  logic               fail, enter_write, tmo, aw_ok, w_ok;

  // NEXT looks up the following entry so WRITE can load it on entry
  always_comb begin
    tbl_idx  = (state_q == NEXT) ? idx_q + 6'd1 : idx_q;
    tbl_addr = '0;
    tbl_data = '0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      if (tbl_idx == 6'(i)) begin
        tbl_addr = INIT_ADDR[i*ADDR_W +: ADDR_W];
        tbl_data = INIT_DATA[i*32 +: 32];
      end
  end

  assign tmo   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign aw_ok = aw_done_q | (awvalid_q & m_axi_awready);
  assign w_ok  = w_done_q  | (wvalid_q  & m_axi_wready);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    retry_d     = retry_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    err_index_d = err_index_q;
    err_code_d  = err_code_q;
    fail        = 1'b0;
    fail_code   = 2'b00;
    enter_write = 1'b0;
    case (state_q)
      DELAY: if (cnt_q >= CNT_W'(DLY_LAST)) enter_write = 1'b1;
      WRITE: begin
        if (aw_ok && w_ok) begin
          state_d   = BRESP;
          cnt_d     = '0;
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          bready_d  = 1'b1;
        end else if (tmo) begin
          fail      = 1'b1;
          fail_code = 2'b10;
        end else begin
          // first WRITE cycle launches both valids; each then holds until its own handshake
          awvalid_d = ~aw_ok;
          wvalid_d  = ~w_ok;
          aw_done_d = aw_ok;
          w_done_d  = w_ok;
        end
      end
      BRESP: begin
        if (bready_q && m_axi_bvalid) begin
          bready_d = 1'b0;
          cnt_d    = '0;
          if (m_axi_bresp != 2'b00) begin
            fail      = 1'b1;
            fail_code = 2'b01;
          end else if (HAS_VFY && VMASK[idx_q]) begin
            state_d  = RADDR;
            araddr_d = awaddr_q;
          end else begin
            state_d = NEXT;
          end
        end else if (tmo) begin
          fail      = 1'b1;
          fail_code = 2'b10;
        end
      end
      RADDR: begin
        if (arvalid_q && m_axi_arready) begin
          state_d   = RDATA;
          cnt_d     = '0;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else if (tmo) begin
          fail      = 1'b1;
          fail_code = 2'b10;
        end else begin
          arvalid_d = 1'b1;
        end
      end
      RDATA: begin
        if (rready_q && m_axi_rvalid) begin
          rready_d = 1'b0;
          cnt_d    = '0;
          if (m_axi_rresp != 2'b00) begin
            fail      = 1'b1;
            fail_code = 2'b01;
          end else if (m_axi_rdata != wdata_q) begin
            fail      = 1'b1;
            fail_code = 2'b11;
          end else begin
            state_d = NEXT;
          end
        end else if (tmo) begin
          fail      = 1'b1;
          fail_code = 2'b10;
        end
      end
      NEXT: begin
        retry_d = '0;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          idx_d       = idx_q + 6'd1;
          enter_write = 1'b1;
        end
      end
      default: begin  // DONE, ERROR
        cnt_d = cnt_q;
        if (start) begin
          state_d     = DELAY;
          cnt_d       = '0;
          idx_d       = '0;
          retry_d     = '0;
          err_index_d = '0;
          err_code_d  = '0;
        end
      end
    endcase

    // a failed attempt abandons any outstanding channel and either retries or gives up
    if (fail) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      if (retry_q < RTY_W'(MAX_RETRIES)) begin
        retry_d     = retry_q + RTY_W'(1);
        enter_write = 1'b1;
      end else begin
        state_d     = ERROR;
        cnt_d       = '0;
        err_index_d = idx_q;
        err_code_d  = fail_code;
      end
    end

    if (enter_write) begin
      state_d   = WRITE;
      cnt_d     = '0;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      awaddr_d  = tbl_addr;
      wdata_d   = tbl_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DELAY;
      cnt_q       <= '0;
      idx_q       <= '0;
      retry_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      err_index_q <= '0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      err_index_q <= err_index_d;
      err_code_q  <= err_code_d;
    end
  end

  assign busy          = (state_q != DONE) && (state_q != ERROR);
  assign done          = (state_q == DONE);
  assign error         = (state_q == ERROR);
  assign err_index     = err_index_q;
  assign err_code      = err_code_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = HAS_VFY & arvalid_q;
  assign m_axi_rready  = HAS_VFY & rready_q;
endmodule

// File: tb/tb_axil_init_sequencer.sv
// Directed bench: default table with entry 0 read-back, 16-cycle timeout, 2 retries,
// driven by a small AXI4-Lite slave model with per-test fault knobs.
module tb_axil_init_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic        busy, done, error;
  logic [5:0]  err_index;
  logic [1:0]  err_code;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic        m_axi_awready = 1'b0, m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0;
  logic        m_axi_wready, m_axi_arready;
  logic [1:0]  m_axi_bresp = 2'b00, m_axi_rresp;

  always #5 clk = ~clk;

  axil_init_sequencer #(
    .VERIFY_MASK(2'b01), .TIMEOUT_CYCLES(16), .MAX_RETRIES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .error(error),
    .err_index(err_index), .err_code(err_code),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // slave knobs, written only by the test tasks
  int          aw_wait    = 0;
  bit          slverr_408 = 1'b0, b_mute = 1'b0;
  logic [31:0] rdata_val  = 32'h1000_0000;

  assign m_axi_wready  = 1'b1;
  assign m_axi_arready = 1'b1;
  assign m_axi_rresp   = 2'b00;
  assign m_axi_rdata   = rdata_val;

  // slave state and logs, written only by the monitor
  bit          aw_got, w_got, b_pend, r_pend, addr_moved;
  int          aw_cnt, cyc, w_hs_cyc, n404, n408, rd_cnt, awv_run, awv_len, wv_run, wv_len;
  logic [31:0] aw_l, prev_awaddr, last_araddr;
  logic [1:0]  bresp_l;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; aw_cnt = 0; awv_run = 0; wv_run = 0;
    end else begin
      if (m_axi_awvalid) begin
        if (awv_run > 0 && m_axi_awaddr !== prev_awaddr) addr_moved = 1;
        prev_awaddr = m_axi_awaddr;
        awv_run++;
        if (m_axi_awready) begin
          aw_got = 1; aw_l = m_axi_awaddr; awv_len = awv_run; awv_run = 0; aw_cnt = 0;
        end else aw_cnt++;
      end
      if (m_axi_wvalid) begin
        wv_run++;
        if (m_axi_wready) begin w_got = 1; wv_len = wv_run; wv_run = 0; end
      end
      if (m_axi_bvalid && m_axi_bready) b_pend = 0;
      if (m_axi_rvalid && m_axi_rready) r_pend = 0;
      if (m_axi_arvalid && m_axi_arready) begin r_pend = 1; rd_cnt++; last_araddr = m_axi_araddr; end
      if (aw_got && w_got) begin
        aw_got = 0; w_got = 0; w_hs_cyc = cyc;
        if (aw_l == 32'h404) n404++;
        else if (aw_l == 32'h408) n408++;
        bresp_l = (slverr_408 && aw_l == 32'h408) ? 2'b10 : 2'b00;
        b_pend  = !b_mute;
      end
    end
  end

  // slave outputs change only on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      m_axi_awready = 0; m_axi_bvalid = 0; m_axi_rvalid = 0;
    end else begin
      m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_wait);
      m_axi_bvalid  = b_pend;
      m_axi_bresp   = bresp_l;
      m_axi_rvalid  = r_pend;
    end
  end

  int vecs = 0, errs = 0;
  int b404, b408, brd;

  task automatic snap;
    b404 = n404; b408 = n408; brd = rd_cnt;
  endtask

  task automatic pulse_start;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end(output int n);
    n = 0;
    while (!(done || error) && n < 2000) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL reset_busy: got %b want 1", busy); end
    vecs++; if ({done, error} !== 2'b00) begin errs++; $display("FAIL reset_status: got %b want 00", {done, error}); end
    vecs++; if ({err_index, err_code} !== 8'h00) begin errs++; $display("FAIL reset_err: got %h want 00", {err_index, err_code}); end
    vecs++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0) begin
      errs++; $display("FAIL reset_handshake: got %b want 00000", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}); end
    vecs++; if (m_axi_wstrb !== 4'hF) begin errs++; $display("FAIL reset_wstrb: got %h want f", m_axi_wstrb); end
    vecs++; if ({m_axi_awaddr, m_axi_wdata} !== 64'h0) begin errs++; $display("FAIL reset_addr_data: got %h want 0", {m_axi_awaddr, m_axi_wdata}); end
  endtask

  // 100 delay + entry 0 (launch, AW/W, B, AR launch, AR, R, NEXT) + entry 1 (launch, AW/W, B, NEXT)
  task automatic test_basic;
    int n;
    snap();
    @(negedge clk); rst_n = 1'b1;
    wait_end(n);
    vecs++; if (n !== 111) begin errs++; $display("FAIL basic_cycles: got %0d want 111", n); end
    vecs++; if ({done, error, busy} !== 3'b100) begin errs++; $display("FAIL basic_status: got %b want 100", {done, error, busy}); end
    vecs++; if (n404 - b404 !== 1 || n408 - b408 !== 1) begin errs++; $display("FAIL basic_writes: got %0d/%0d want 1/1", n404 - b404, n408 - b408); end
    vecs++; if (rd_cnt - brd !== 1 || last_araddr !== 32'h404) begin errs++; $display("FAIL basic_readback: got %0d @%h want 1 @404", rd_cnt - brd, last_araddr); end
  endtask

  task automatic test_aw_delay;
    int n;
    aw_wait = 4; addr_moved = 0;
    snap(); pulse_start(); wait_end(n);
    vecs++; if (n !== 119) begin errs++; $display("FAIL awdly_cycles: got %0d want 119", n); end
    vecs++; if (awv_len !== 5) begin errs++; $display("FAIL awdly_awvalid_len: got %0d want 5", awv_len); end
    vecs++; if (wv_len !== 1) begin errs++; $display("FAIL awdly_wvalid_len: got %0d want 1", wv_len); end
    vecs++; if (addr_moved !== 1'b0) begin errs++; $display("FAIL awdly_addr_stable: got %b want 0", addr_moved); end
    vecs++; if (n404 - b404 !== 1 || n408 - b408 !== 1) begin errs++; $display("FAIL awdly_writes: got %0d/%0d want 1/1", n404 - b404, n408 - b408); end
    aw_wait = 0;
  endtask

  task automatic test_slverr;
    int n;
    slverr_408 = 1;
    snap(); pulse_start(); wait_end(n);
    vecs++; if ({done, error, busy} !== 3'b010) begin errs++; $display("FAIL slverr_status: got %b want 010", {done, error, busy}); end
    vecs++; if (err_index !== 6'd1 || err_code !== 2'b01) begin errs++; $display("FAIL slverr_err: got idx %0d code %b want idx 1 code 01", err_index, err_code); end
    vecs++; if (n408 - b408 !== 3 || n404 - b404 !== 1) begin errs++; $display("FAIL slverr_writes: got %0d/%0d want 1/3", n404 - b404, n408 - b408); end
    slverr_408 = 0;
  endtask

  task automatic test_verify;
    int n;
    rdata_val = 32'h0;
    snap(); pulse_start(); wait_end(n);
    vecs++; if ({done, error} !== 2'b01) begin errs++; $display("FAIL vfy_bad_status: got %b want 01", {done, error}); end
    vecs++; if (err_index !== 6'd0 || err_code !== 2'b11) begin errs++; $display("FAIL vfy_bad_err: got idx %0d code %b want idx 0 code 11", err_index, err_code); end
    vecs++; if (n404 - b404 !== 3 || rd_cnt - brd !== 3 || n408 - b408 !== 0) begin
      errs++; $display("FAIL vfy_bad_traffic: got w404 %0d rd %0d w408 %0d want 3 3 0", n404 - b404, rd_cnt - brd, n408 - b408); end
    rdata_val = 32'h1000_0000;
    pulse_start(); wait_end(n);
    vecs++; if ({done, error, err_code} !== 4'b1000) begin errs++; $display("FAIL vfy_good: got %b want 1000", {done, error, err_code}); end
  endtask

  task automatic test_timeout;
    int n;
    b_mute = 1;
    snap(); pulse_start(); wait_end(n);
    vecs++; if ({done, error} !== 2'b01 || err_code !== 2'b10 || err_index !== 6'd0) begin
      errs++; $display("FAIL tmo_err: got de %b code %b idx %0d want 01 10 0", {done, error}, err_code, err_index); end
    vecs++; if (cyc - w_hs_cyc !== 16) begin errs++; $display("FAIL tmo_latency: got %0d want 16", cyc - w_hs_cyc); end
    vecs++; if (n404 - b404 !== 3) begin errs++; $display("FAIL tmo_attempts: got %0d want 3", n404 - b404); end
    b_mute = 0;
    snap(); pulse_start();
    vecs++; if ({busy, error, err_code, err_index} !== {1'b1, 1'b0, 2'b00, 6'd0}) begin
      errs++; $display("FAIL tmo_restart_clear: got %b want 1000000000", {busy, error, err_code, err_index}); end
    wait_end(n);
    vecs++; if (done !== 1'b1 || n404 - b404 !== 1) begin errs++; $display("FAIL tmo_rerun: got done %b w404 %0d want 1 1", done, n404 - b404); end
  endtask

  task automatic test_reset_mid;
    int n;
    b_mute = 1;
    pulse_start();
    n = 0;
    while (m_axi_bready !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    vecs++; if (m_axi_bready !== 1'b1) begin errs++; $display("FAIL rstmid_reach_bresp: got %b want 1", m_axi_bready); end
    #2 rst_n = 1'b0;
    #1;
    vecs++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0) begin
      errs++; $display("FAIL rstmid_async_drop: got %b want 00000", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}); end
    vecs++; if ({busy, done, error} !== 3'b100) begin errs++; $display("FAIL rstmid_status: got %b want 100", {busy, done, error}); end
    repeat (2) @(negedge clk);
    b_mute = 0;
    snap();
    rst_n = 1'b1;
    wait_end(n);
    vecs++; if (n !== 111 || done !== 1'b1) begin errs++; $display("FAIL rstmid_rerun: got %0d cycles done %b want 111 1", n, done); end
    vecs++; if (n404 - b404 !== 1 || n408 - b408 !== 1) begin errs++; $display("FAIL rstmid_writes: got %0d/%0d want 1/1", n404 - b404, n408 - b408); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_aw_delay();
    test_slverr();
    test_verify();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
